tick_pwm: RTL and testbench



---
 rtl/tick_pwm.sv | 107 ++++++++++
 tb/tb_tick_pwm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tick_pwm.sv
// Tick-driven PWM: one phase step per upstream strobe, duty loaded through a
// valid/ready shadow register and applied only at a period wrap or while idle.
module tick_pwm #(
  parameter int PERIOD = 8,
  parameter int DW     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      en,
  input  logic [DW-1:0]             duty_in,
  input  logic                      duty_valid,
  output logic                      duty_ready,
  output logic                      pwm_out,
  output logic                      period_end,
  output logic [$clog2(PERIOD)-1:0] phase
);

  localparam int PW = $clog2(PERIOD);
  localparam logic [PW-1:0] LAST_PHASE  = PW'(PERIOD - 1);
  localparam logic [DW-1:0] PERIOD_DUTY = DW'(PERIOD);

  logic [PW-1:0] phase_q, phase_d;
  logic [DW-1:0] active_q, active_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] pend_val_q, pend_val_d;
  logic          period_end_q, period_end_d;
  logic          xfer_s;
  logic          wrap_s;

  // Requests above PERIOD mean "always high", so clamp them to PERIOD.
  function automatic logic [DW-1:0] sat_duty(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    if (d > PERIOD_DUTY) begin
      r = PERIOD_DUTY;
    end else begin
      r = d;
    end
    return r;
  endfunction

  assign xfer_s = duty_valid && !pend_q;
  assign wrap_s = tick && (phase_q == LAST_PHASE);

  // Next-state: phase stepping, shadow-register load and apply.
  always_comb begin
    phase_d      = phase_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_val_d   = pend_val_q;
    period_end_d = 1'b0;

    if (!en) begin
      phase_d = '0;
      if (pend_q) begin
        active_d = pend_val_q;
        pend_d   = 1'b0;
      end else begin
        pend_d = pend_q;
      end
    end else if (wrap_s) begin
      phase_d      = '0;
      period_end_d = 1'b1;
      if (pend_q) begin
        active_d = pend_val_q;
        pend_d   = 1'b0;
      end else begin
        pend_d = pend_q;
      end
    end else if (tick) begin
      phase_d = phase_q + PW'(1);
    end else begin
      phase_d = phase_q;
    end

    // Only reachable with pend_q low, so it never competes with an apply.
    if (xfer_s) begin
      pend_d     = 1'b1;
      pend_val_d = sat_duty(duty_in);
    end else begin
      pend_val_d = pend_val_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= '0;
      active_q     <= '0;
      pend_q       <= 1'b0;
      pend_val_q   <= '0;
      period_end_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_val_q   <= pend_val_d;
      period_end_q <= period_end_d;
    end
  end

  assign duty_ready = !pend_q;
  assign pwm_out    = en && (DW'(phase_q) < active_q);
  assign period_end = period_end_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_tick_pwm.sv
// Directed self-checking bench for tick_pwm (PERIOD=8, DW=4).
module tb_tick_pwm;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       en;
  logic [3:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_out;
  logic       period_end;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  tick_pwm #(.PERIOD(8), .DW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .en         (en),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic load(input logic [3:0] d);
    duty_in    = d;
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
  endtask

  // One full period starting at phase 0 with back-to-back ticks.
  task automatic period_check(input int exp_duty, input string tag);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_phase"}, 32'(phase), 32'(i));
      chk({tag, "_pwm"}, 32'(pwm_out), (i < exp_duty) ? 32'd1 : 32'd0);
      do_tick();
      chk({tag, "_pe"}, 32'(period_end), (i == 7) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int exp_phase;
    int hi_cnt;
    int pe_cnt;
    logic exp_pe;

    reset = 1'b1; tick = 1'b0; en = 1'b0; duty_in = 4'd0; duty_valid = 1'b0;
    step();
    step();
    reset = 1'b0;

    // 1. reset and idle
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_pe", 32'(period_end), 32'd0);
    chk("rst_ready", 32'(duty_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      do_tick();
      chk("idle_phase", 32'(phase), 32'd0);
      chk("idle_pe", 32'(period_end), 32'd0);
      chk("idle_pwm", 32'(pwm_out), 32'd0);
      chk("idle_ready", 32'(duty_ready), 32'd1);
    end

    // 2. basic PWM, duty 3, tick every 5 clocks
    load(4'd3);
    chk("idle_load_ready0", 32'(duty_ready), 32'd0);
    step();
    chk("idle_apply_ready1", 32'(duty_ready), 32'd1);
    chk("idle_apply_pwm", 32'(pwm_out), 32'd0);
    en = 1'b1;
    #1;
    chk("en_pwm", 32'(pwm_out), 32'd1);
    exp_phase = 0; hi_cnt = 0; pe_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      tick = ((k % 5) == 4);
      step();
      exp_pe = 1'b0;
      if (tick) begin
        exp_phase = (exp_phase + 1) % 8;
        exp_pe = (exp_phase == 0);
      end
      tick = 1'b0;
      chk("pwm5_phase", 32'(phase), 32'(exp_phase));
      chk("pwm5_pe", 32'(period_end), 32'(exp_pe));
      chk("pwm5_pwm", 32'(pwm_out), (exp_phase < 3) ? 32'd1 : 32'd0);
      if (pwm_out) hi_cnt++;
      if (period_end) pe_cnt++;
      if (k == 39) begin
        chk("pwm5_hi_first40", 32'(hi_cnt), 32'd15);
        chk("pwm5_pe_first40", 32'(pe_cnt), 32'd1);
      end
    end
    chk("pwm5_hi_total", 32'(hi_cnt), 32'd30);
    chk("pwm5_pe_total", 32'(pe_cnt), 32'd2);

    // 3. boundary-only update: load 6 at phase 4
    for (int i = 0; i < 4; i++) do_tick();
    chk("bnd_phase4", 32'(phase), 32'd4);
    load(4'd6);
    chk("bnd_ready0", 32'(duty_ready), 32'd0);
    for (int i = 5; i < 8; i++) begin
      do_tick();
      chk("bnd_hold_ready", 32'(duty_ready), 32'd0);
      chk("bnd_old_pwm", 32'(pwm_out), 32'd0);
    end
    do_tick();
    chk("bnd_wrap_pe", 32'(period_end), 32'd1);
    chk("bnd_wrap_ready", 32'(duty_ready), 32'd1);
    period_check(6, "bnd_d6");

    // 4. saturation and extremes
    load(4'd15);
    chk("sat15_ready0", 32'(duty_ready), 32'd0);
    period_check(6, "sat_prev6");
    load(4'd8);
    period_check(8, "sat15");
    load(4'd0);
    period_check(8, "sat8");
    period_check(0, "zero");

    // 5. collision: transfer on the wrap edge
    load(4'd3);
    period_check(0, "col_prev0");
    for (int i = 0; i < 7; i++) do_tick();
    chk("col_phase7", 32'(phase), 32'd7);
    duty_in = 4'd5; duty_valid = 1'b1; tick = 1'b1;
    step();
    duty_valid = 1'b0; tick = 1'b0;
    chk("col_pe", 32'(period_end), 32'd1);
    chk("col_ready0", 32'(duty_ready), 32'd0);
    period_check(3, "col_old3");
    chk("col_ready1", 32'(duty_ready), 32'd1);
    period_check(5, "col_new5");

    // 6. reset mid-period with a pending duty
    for (int i = 0; i < 5; i++) do_tick();
    chk("mrst_phase5", 32'(phase), 32'd5);
    load(4'd2);
    chk("mrst_pend_ready", 32'(duty_ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_phase", 32'(phase), 32'd0);
    chk("mrst_ready", 32'(duty_ready), 32'd1);
    chk("mrst_pwm", 32'(pwm_out), 32'd0);
    chk("mrst_pe", 32'(period_end), 32'd0);
    period_check(0, "mrst_nopend");

    // disabling mid-period returns phase to 0 without a period_end
    load(4'd4);
    period_check(0, "dis_prev0");
    for (int i = 0; i < 3; i++) do_tick();
    en = 1'b0;
    do_tick();
    chk("dis_phase", 32'(phase), 32'd0);
    chk("dis_pe", 32'(period_end), 32'd0);
    chk("dis_pwm", 32'(pwm_out), 32'd0);
    en = 1'b1;
    #1;
    chk("reen_pwm", 32'(pwm_out), 32'd1);
    period_check(4, "reen_d4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
